// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access width encodings,
// responder FSM states and the captured request record.
// Combinational helpers only; no timing or backpressure of its own.
package dmem_pkg;

  // funct3-style access width encodings
  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request fields captured on acceptance
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  width;
    logic [31:0] wdata;
  } req_t;

  // Unsigned widths only make sense for loads; anything else outside the
  // five encodings is illegal.
  function automatic logic width_legal(input logic [2:0] width, input logic we);
    logic ok;
    ok = 1'b0;
    case (width)
      W_B, W_H, W_W: ok = 1'b1;
      W_BU, W_HU:    ok = !we;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store initiator and dmem_responder.
// Request side is valid/ready; response side is valid/ready, held until taken.
// master = initiator, slave = responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_width;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_width, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_width, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_align.sv
// Lane alignment for one access: store replication, byte enables, load
// extraction/extension and misalignment/illegal-width detection.
// Purely combinational (0 cycles); no backpressure.
// Ports: addr_lo/width/we/wdata describe the access, rword is the addressed
// memory word; wdata_rep/be drive the write, rdata/err form the response.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  width,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wdata_rep,
  output logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;

  always_comb begin
    wdata_rep = wdata;
    be        = 4'b0000;
    err       = !width_legal(width, we);
    ext       = 32'h0;

    case (addr_lo)
      2'd0:    lane_b = rword[7:0];
      2'd1:    lane_b = rword[15:8];
      2'd2:    lane_b = rword[23:16];
      default: lane_b = rword[31:24];
    endcase
    lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];

    case (width)
      W_B, W_BU: begin
        wdata_rep = {4{wdata[7:0]}};
        be        = 4'b0001 << addr_lo;
        ext       = (width == W_B) ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      end
      W_H, W_HU: begin
        wdata_rep = {2{wdata[15:0]}};
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        ext       = (width == W_H) ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
        if (addr_lo[0]) err = 1'b1;
      end
      W_W: begin
        be  = 4'b1111;
        ext = rword;
        if (addr_lo != 2'd0) err = 1'b1;
      end
      default: begin
        be  = 4'b0000;
        ext = 32'h0;
      end
    endcase

    // An erroring access must leave memory untouched and return zero.
    if (err) be = 4'b0000;
    rdata = (we || err) ? 32'h0 : ext;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with 2^N 32-bit words.
// Response appears LATENCY (1..15) cycles after acceptance; one request at a time.
// req_ready only in IDLE; response held until rsp_ready, no same-cycle bypass.
// Ports: clk, rst (async, active-low), bus (slave side of dmem_responder_if).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int N       = 17,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  // Memory: no reset, contents survive rst.
  logic [31:0] mem [0:(1<<N)-1];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        ready_en_q, ready_en_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept;
  logic        do_access;
  logic        mem_we;
  req_t        req_in;
  req_t        acc;
  logic [N-1:0] acc_idx;
  logic [31:0] rword;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_rdata;
  logic        al_err;

  // Address bits above the word index are deliberately ignored (wrap).
  logic        unused_addr_hi;

  assign req_in = '{addr:  bus.req_addr,
                    we:    bus.req_we,
                    width: bus.req_width,
                    wdata: bus.req_wdata};

  // ready_en_q keeps req_ready low until the first edge after reset release.
  assign bus.req_ready = (state_q == IDLE) && ready_en_q;
  assign accept        = bus.req_valid && bus.req_ready;

  // With LATENCY=1 the access happens on the acceptance edge, so it must use
  // the live request; otherwise the captured copy is used from WAIT.
  assign acc            = (state_q == IDLE) ? req_in : req_q;
  assign acc_idx        = acc.addr[N+1:2];
  assign unused_addr_hi = ^acc.addr[31:N+2];
  assign rword          = mem[acc_idx];

  dmem_align u_align (
    .addr_lo   (acc.addr[1:0]),
    .width     (acc.width),
    .we        (acc.we),
    .wdata     (acc.wdata),
    .rword     (rword),
    .wdata_rep (al_wdata),
    .be        (al_be),
    .rdata     (al_rdata),
    .err       (al_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ready_en_d  = 1'b1;
    do_access   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = req_in;
          if (LATENCY == 1) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Access on the edge that leaves WAIT so rsp_valid rises exactly
        // LATENCY cycles after acceptance.
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          cnt_d     = 4'd0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_access) begin
      rsp_rdata_d = al_rdata;
      rsp_err_d   = al_err;
    end
  end

  assign mem_we = do_access && acc.we && !al_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      ready_en_q  <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      ready_en_q  <= ready_en_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Reset holds the FSM in IDLE, so mem_we is low and nothing is written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (al_be[i]) mem[acc_idx][8*i +: 8] <= al_wdata[8*i +: 8];
      end
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int NT = 17;

  logic        clk;
  logic        rst;
  logic        sel;          // 0: dut_a (LATENCY=2), 1: dut_b (LATENCY=1)
  logic        t_valid;
  logic        t_we;
  logic [2:0]  t_width;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic        t_rsp_ready;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;

  int n_checks = 0;
  int n_err    = 0;

  // Reference memory: byte-addressed, keyed by {dut select, wrapped address}
  logic [7:0] mm [longint];

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  assign ifa.req_valid = t_valid & ~sel;
  assign ifa.req_addr  = t_addr;
  assign ifa.req_we    = t_we;
  assign ifa.req_width = t_width;
  assign ifa.req_wdata = t_wdata;
  assign ifa.rsp_ready = t_rsp_ready & ~sel;
  assign ifb.req_valid = t_valid & sel;
  assign ifb.req_addr  = t_addr;
  assign ifb.req_we    = t_we;
  assign ifb.req_width = t_width;
  assign ifb.req_wdata = t_wdata;
  assign ifb.rsp_ready = t_rsp_ready & sel;

  assign o_ready = sel ? ifb.req_ready : ifa.req_ready;
  assign o_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
  assign o_rdata = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
  assign o_err   = sel ? ifb.rsp_err   : ifa.rsp_err;

  dmem_responder #(.N(NT), .LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dmem_responder #(.N(NT), .LATENCY(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural model: size from width, alignment/legality rules, little-endian bytes.
  function automatic void model(input logic s, input logic [31:0] a, input logic we,
                                input logic [2:0] w, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int          sz;
    longint      k;
    logic [31:0] v;
    rd = 32'h0;
    er = 1'b0;
    case (w[1:0])
      2'd0:    sz = 1;
      2'd1:    sz = 2;
      2'd2:    sz = 4;
      default: sz = 0;
    endcase
    if (sz == 0 || (w[2] && sz == 4) || (we && w[2]) || (a % sz) != 0) begin
      er = 1'b1;
      return;
    end
    k = (longint'(s) << 32) | longint'(a % (32'd4 << NT));
    if (we) begin
      for (int i = 0; i < sz; i++) mm[k + i] = wd[8*i +: 8];
      return;
    end
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(mm[k + i]) << (8 * i));
    if (!w[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    rd = v;
  endfunction

  // One complete transaction on the selected DUT; entered and left at a negedge.
  task automatic txn(input logic [31:0] a, input logic we, input logic [2:0] w,
                     input logic [31:0] wd, input int hold, input int exp_lat,
                     output logic [31:0] rd, output logic er);
    logic [31:0] e_rd;
    logic        e_er;
    int          t;
    int          lat;
    model(sel, a, we, w, wd, e_rd, e_er);
    t_addr = a; t_we = we; t_width = w; t_wdata = wd; t_valid = 1'b1;
    t = 0;
    while (!o_ready && t < 20) begin @(negedge clk); t++; end
    chk("accept_wait", 32'(t < 20), 32'd1);
    if (t >= 20) begin
      t_valid = 1'b0; rd = 32'h0; er = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Junk on the request fields while busy must have no effect.
    t_valid = 1'b0;
    t_addr  = $urandom;
    t_we    = 1'($urandom_range(1));
    t_width = 3'($urandom_range(7));
    t_wdata = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!o_valid && lat < 40);
    chk("latency", 32'(lat), 32'(exp_lat));
    rd = o_rdata;
    er = o_err;
    chk("rdata", rd, e_rd);
    chk("err", 32'(er), 32'(e_er));
    chk("ready_in_resp", 32'(o_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_rdata", o_rdata, rd);
      chk("hold_err", 32'(o_err), 32'(er));
      chk("hold_ready", 32'(o_ready), 32'd0);
    end
    t_rsp_ready = 1'b1;
    @(posedge clk); #1;
    t_rsp_ready = 1'b0;
    @(negedge clk);
    chk("valid_dropped", 32'(o_valid), 32'd0);
    chk("ready_after_hs", 32'(o_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;

    sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_width = 3'b0;
    t_addr = 32'h0; t_wdata = 32'h0; t_rsp_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_req_ready", 32'(ifa.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", ifa.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(ifa.rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("rst_held_ready", 32'(ifa.req_ready), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("rel_ready_before_edge", 32'(ifa.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_ready_after_edge", 32'(ifa.req_ready), 32'd1);
    chk("rel_ready_b", 32'(ifb.req_ready), 32'd1);
    @(negedge clk);

    // Word store then load
    txn(32'h100, 1'b1, W_W, 32'hDEADBEEF, 0, 2, rd, er);
    chk("sw_rdata", rd, 32'h0);
    txn(32'h100, 1'b0, W_W, 32'h0, 0, 2, rd, er);
    chk("lw_100", rd, 32'hDEADBEEF);
    chk("lw_100_err", 32'(er), 32'd0);

    // Byte store and sub-word loads
    txn(32'h101, 1'b1, W_B, 32'h0000007F, 0, 2, rd, er);
    txn(32'h100, 1'b0, W_B, 32'h0, 0, 2, rd, er);
    chk("lb_100", rd, 32'hFFFFFFEF);
    txn(32'h100, 1'b0, W_BU, 32'h0, 0, 2, rd, er);
    chk("lbu_100", rd, 32'h000000EF);
    txn(32'h100, 1'b0, W_H, 32'h0, 0, 2, rd, er);
    chk("lh_100", rd, 32'h00007FEF);
    txn(32'h100, 1'b0, W_HU, 32'h0, 0, 2, rd, er);
    chk("lhu_100", rd, 32'h00007FEF);
    txn(32'h100, 1'b0, W_W, 32'h0, 0, 2, rd, er);
    chk("lw_100_after_sb", rd, 32'hDEAD7FEF);

    // Error cases must not touch memory
    txn(32'h102, 1'b0, W_W, 32'h0, 0, 2, rd, er);
    chk("lw_102_err", 32'(er), 32'd1);
    chk("lw_102_rdata", rd, 32'h0);
    txn(32'h103, 1'b1, W_H, 32'h0000AAAA, 0, 2, rd, er);
    chk("sh_103_err", 32'(er), 32'd1);
    txn(32'h100, 1'b1, W_BU, 32'hFFFFFFFF, 0, 2, rd, er);
    chk("sw_bu_err", 32'(er), 32'd1);
    chk("sw_bu_rdata", rd, 32'h0);
    txn(32'h100, 1'b0, 3'b111, 32'h0, 0, 2, rd, er);
    chk("illegal_w_err", 32'(er), 32'd1);
    txn(32'h100, 1'b0, W_W, 32'h0, 0, 2, rd, er);
    chk("lw_100_after_err", rd, 32'hDEAD7FEF);

    // Response backpressure for 5 cycles
    txn(32'h100, 1'b0, W_W, 32'h0, 5, 2, rd, er);
    chk("lw_100_held", rd, 32'hDEAD7FEF);

    // Reset during WAIT drops the store
    txn(32'h200, 1'b1, W_W, 32'hA5A5A5A5, 0, 2, rd, er);
    txn(32'h200, 1'b0, W_W, 32'h0, 0, 2, rd, er);
    chk("lw_200_pre", rd, 32'hA5A5A5A5);
    t_addr = 32'h200; t_we = 1'b1; t_width = W_W; t_wdata = 32'h55; t_valid = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    chk("wait_no_valid", 32'(ifa.rsp_valid), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("mid_rst_rdata", ifa.rsp_rdata, 32'h0);
    chk("mid_rst_err", 32'(ifa.rsp_err), 32'd0);
    chk("mid_rst_ready", 32'(ifa.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 chk("mid_rel_ready0", 32'(ifa.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rel_ready1", 32'(ifa.req_ready), 32'd1);
    @(negedge clk);
    txn(32'h200, 1'b0, W_W, 32'h0, 0, 2, rd, er);
    chk("lw_200_post", rd, 32'hA5A5A5A5);

    // LATENCY=1 instance and address wrap
    sel = 1'b1;
    txn(32'h0, 1'b1, W_W, 32'h12345678, 0, 1, rd, er);
    txn(32'd4 << NT, 1'b0, W_W, 32'h0, 0, 1, rd, er);
    chk("lw_wrap", rd, 32'h12345678);
    chk("lw_wrap_err", 32'(er), 32'd0);
    sel = 1'b0;

    // Randomized phase: prefill a window, then mixed accesses with upper-bit aliasing
    for (int i = 0; i < 16; i++) begin
      a = (32'h300 + 32'(4 * i)) | ($urandom & 32'hFFF8_0000);
      txn(a, 1'b1, W_W, $urandom, 0, 2, rd, er);
    end
    for (int i = 0; i < 60; i++) begin
      a = (32'h300 + 32'($urandom_range(63))) | ($urandom & 32'hFFF8_0000);
      txn(a, 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom,
          int'($urandom_range(2)), 2, rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
